sprite_uart_loader: RTL and testbench
=====================================

// Module: sprite_uart_loader
// PURPOSE
//   Write side of the sprite/background SRAMs that the VGA renderer reads. Receives image
//   packets over a UART (8N1), assembles 12-bit RGB pixels and issues one-cycle SRAM writes
//   to the selected store (bg / P1 / P2 / ball). Lets art be reloaded without a rebuild.
//   Sits between the board UART RX pin and the SRAM write ports, clocked by the system clk.
// PARAMETERS
//   CLK_HZ       100_000_000  system clock frequency
//   BAUD         115200       UART bit rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer divide)
//   BG_SIZE      76800        bg pixels (320*240)
//   PIKA_SIZE    4096         P1/P2 pixels (64*64)
//   BALL_SIZE    1600         ball pixels (40*40)
//   TIMEOUT_CYC  2_000_000    max idle cycles between bytes inside a packet
// PORTS
//   clk       in   1   system clock
//   reset_n   in   1   reset, asynchronous, active-low
//   uart_rx   in   1   serial input, idle high, asynchronous to clk
//   wr_en     out  1   SRAM write strobe, one cycle per pixel
//   wr_sel    out  2   target store: 0 bg, 1 P1, 2 P2, 3 ball
//   wr_addr   out  17  pixel address within the target, row-major from 0
//   wr_data   out  12  pixel {R[3:0],G[3:0],B[3:0]}
//   busy      out  1   high whenever the FSM is not in IDLE
//   done      out  1   one-cycle pulse: packet completed without error
//   err       out  1   one-cycle pulse: framing, header, checksum or timeout error
// BEHAVIOUR
//   Reset: every output 0, FSM in IDLE, address counter 0, checksum 0, RX idle.
//   RX: 2-flop synchroniser on uart_rx. A falling edge starts a frame. Sample at mid-bit
//     (CLKS_PER_BIT/2 after the start edge, then every CLKS_PER_BIT). Start bit re-checked low
//     at mid-bit, else discard. LSB first. stop=0 -> byte dropped, err pulse, FSM->IDLE.
//     Good byte -> byte_valid high for 1 cycle.
//   Packet: 0xA5, target byte, N pixels x {hi byte (low nibble=R, upper nibble ignored),
//     lo byte (G,B)}, [checksum]. N = size of target.
//   FSM states: IDLE, HDR, PIX_HI, PIX_LO, CHK, FIN.
//     IDLE: non-0xA5 bytes ignored (no err); 0xA5 -> HDR.
//     HDR: byte<=3 -> latch wr_sel, addr=0, PIX_HI. Byte>3 -> err, IDLE.
//     PIX_HI: latch R nibble -> PIX_LO.
//     PIX_LO: cycle after lo byte_valid: wr_en=1, wr_addr=current addr, wr_data={R,lo}.
//       If addr==N-1 -> CHK (or FIN when macro off), else addr+1 -> PIX_HI.
//     FIN: done pulse next cycle, -> IDLE.
//   wr_sel/wr_addr/wr_data are registered and stable while wr_en=1. They hold their last
//     values otherwise.
//   Timeout: in any non-IDLE state, TIMEOUT_CYC cycles without byte_valid -> err, IDLE.
//     Writes already issued are not undone. The counter clears on each byte_valid.
//   Async reset mid-packet: immediate return to reset values. The partial image stays in SRAM.
//   done and err never assert in the same cycle. A byte arriving during the FIN cycle is
//     handled in IDLE.
// CONFIGURATION
//   LOADER_CHECKSUM_EN defined: a trailing byte follows the pixels. It must equal the XOR of
//     all bytes after the target byte. Match -> FIN/done. Mismatch -> err, IDLE.
//   Not defined: CHK state absent. The last pixel write goes straight to FIN.
//     No trailing byte is expected; an extra byte is treated as IDLE traffic.
// STRUCTURE
//   Shared package: target ids (TGT_BG..TGT_BALL), SYNC_BYTE=8'hA5, size constants,
//     FSM state enum.
//   Sub-module uart_rx_byte (sync, bit timing, framing check -> byte/byte_valid/frame_err).
//   The top instantiates it and implements the packet FSM, address counter and timeout.
// TESTING
//   1 Reset release, uart_rx idle 1 ms -> all outputs 0, busy 0, no wr_en.
//   2 Send A5,03, 1600 pixel pairs 0F,0F -> 1600 wr_en with sel=3, addr 0..1599 in order,
//     data 12'hF0F. Then done pulse once, busy falls (add checksum byte when macro on).
//   3 Send 5A,A5,04 -> first byte ignored, err pulse after 04, no wr_en, busy 0.
//   4 Send A5,01,12,34 then stop 30 ms -> one write addr 0 data 12'h234, then err on timeout.
//     Then a full valid P1 packet still completes with done.
//   5 Byte with stop bit forced 0 mid-pixel -> err pulse, IDLE. Assert reset_n low
//     mid-bg-packet -> outputs 0 within the same cycle.
//   6 LOADER_CHECKSUM_EN: ball packet with wrong checksum -> 1600 writes, err, no done.
//     Correct checksum -> done.

Source files
------------

// File: rtl/sprite_uart_loader_pkg.sv
// Shared definitions for the sprite/background UART loader.
//   Target ids for the four image stores, packet sync byte, default store
//   sizes, SRAM address width and the state encodings of the packet FSM and
//   the UART receiver.
// Optional feature macro: LOADER_CHECKSUM_EN adds the CHK state, used when a
//   trailing XOR checksum byte follows the pixel data.
package sprite_uart_loader_pkg;

    localparam logic [1:0] TGT_BG   = 2'd0;
    localparam logic [1:0] TGT_P1   = 2'd1;
    localparam logic [1:0] TGT_P2   = 2'd2;
    localparam logic [1:0] TGT_BALL = 2'd3;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    localparam int BG_SIZE_DEF   = 76800;
    localparam int PIKA_SIZE_DEF = 4096;
    localparam int BALL_SIZE_DEF = 1600;

    localparam int ADDR_W = 17;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_PIX_HI,
        ST_PIX_LO,
`ifdef LOADER_CHECKSUM_EN
        ST_CHK,
`endif
        ST_FIN
    } ld_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/sprite_uart_loader_rx.sv
// UART 8N1 byte receiver.
//   Synchronises the asynchronous serial line, detects the start edge,
//   samples each bit at its middle and checks the stop bit.
// Ports:
//   i_clk          system clock
//   i_reset_n      asynchronous active-low reset
//   i_rx           serial input, idle high
//   o_byte         last received byte (LSB first on the wire)
//   o_byte_valid   one-cycle pulse: o_byte holds a correctly framed byte
//   o_frame_err    one-cycle pulse: stop bit sampled low, byte dropped
module uart_rx_byte
    import sprite_uart_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_rx,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_frame_err
);

    localparam int HALF  = CLKS_PER_BIT / 2;
    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);

    logic             r_rx_s1;
    logic             r_rx_s2;
    logic             r_rx_prev;
    rx_state_t        r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit;
    logic [7:0]       r_shift;
    logic             r_valid;
    logic             r_ferr;

    rx_state_t        w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       w_bit_nxt;
    logic [7:0]       w_shift_nxt;
    logic             w_valid_nxt;
    logic             w_ferr_nxt;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_prev <= 1'b1;
            r_state   <= RX_IDLE;
            r_cnt     <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_rx_s1   <= i_rx;
            r_rx_s2   <= r_rx_s1;
            r_rx_prev <= r_rx_s2;
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bit     <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
            r_valid   <= w_valid_nxt;
            r_ferr    <= w_ferr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_bit_nxt   = r_bit;
        w_shift_nxt = r_shift;
        w_valid_nxt = 1'b0;
        w_ferr_nxt  = 1'b0;
        case (r_state)
            RX_IDLE: begin
                w_cnt_nxt = '0;
                // Edge rather than level: after a failed stop bit the line is
                // still low and must not be taken as a new start bit.
                if (r_rx_prev && !r_rx_s2) begin
                    w_state_nxt = RX_START;
                end
            end
            RX_START: begin
                if (r_cnt == CNT_W'(HALF - 1)) begin
                    w_cnt_nxt = '0;
                    w_bit_nxt = '0;
                    // A glitch shorter than half a bit is discarded here.
                    w_state_nxt = r_rx_s2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (r_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {r_rx_s2, r_shift[7:1]};
                    w_bit_nxt   = r_bit + 1'b1;
                    if (r_bit == 3'd7) begin
                        w_state_nxt = RX_STOP;
                    end
                end
            end
            RX_STOP: begin
                if (r_cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                    w_cnt_nxt   = '0;
                    w_valid_nxt = r_rx_s2;
                    w_ferr_nxt  = !r_rx_s2;
                    w_state_nxt = RX_IDLE;
                end
            end
            default: w_state_nxt = RX_IDLE;
        endcase
    end

    assign o_byte       = r_shift;
    assign o_byte_valid = r_valid;
    assign o_frame_err  = r_ferr;

endmodule

// File: rtl/sprite_uart_loader.sv
// Sprite/background SRAM loader fed by a UART.
//   Parses packets  A5, target, N x {hi(R in low nibble), lo(G,B)} [, checksum]
//   and issues one SRAM write per pixel to the selected store.
// Optional feature macro: LOADER_CHECKSUM_EN -- a trailing byte equal to the
//   XOR of all pixel bytes is required before done; otherwise done follows the
//   last pixel write directly.
// Ports:
//   i_clk       system clock
//   i_reset_n   asynchronous active-low reset
//   i_uart_rx   serial input, idle high, asynchronous
//   o_wr_en     SRAM write strobe, one cycle per pixel
//   o_wr_sel    target store: 0 bg, 1 P1, 2 P2, 3 ball
//   o_wr_addr   pixel address within target, row-major from 0
//   o_wr_data   pixel {R,G,B} 4 bits each
//   o_busy      high whenever the packet FSM is not idle
//   o_done      one-cycle pulse: packet completed without error
//   o_err       one-cycle pulse: framing, header, checksum or timeout error
module sprite_uart_loader
    import sprite_uart_loader_pkg::*;
#(
    parameter int CLK_HZ      = 100_000_000,
    parameter int BAUD        = 115200,
    parameter int BG_SIZE     = BG_SIZE_DEF,
    parameter int PIKA_SIZE   = PIKA_SIZE_DEF,
    parameter int BALL_SIZE   = BALL_SIZE_DEF,
    parameter int TIMEOUT_CYC = 2_000_000
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_uart_rx,
    output logic              o_wr_en,
    output logic [1:0]        o_wr_sel,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [11:0]       o_wr_data,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int TMO_W        = $clog2(TIMEOUT_CYC + 1);

    logic [7:0] w_byte;
    logic       w_byte_valid;
    logic       w_frame_err;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .i_clk        (i_clk),
        .i_reset_n    (i_reset_n),
        .i_rx         (i_uart_rx),
        .o_byte       (w_byte),
        .o_byte_valid (w_byte_valid),
        .o_frame_err  (w_frame_err)
    );

    ld_state_t         r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_red;
    logic              r_wr_en;
    logic [1:0]        r_wr_sel;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [11:0]       r_wr_data;
    logic              r_done;
    logic              r_err;
    logic [TMO_W-1:0]  r_tmo_cnt;

    ld_state_t         w_state_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [3:0]        w_red_nxt;
    logic              w_wr_en_nxt;
    logic [1:0]        w_wr_sel_nxt;
    logic [ADDR_W-1:0] w_wr_addr_nxt;
    logic [11:0]       w_wr_data_nxt;
    logic              w_done_nxt;
    logic              w_err_nxt;
    logic              w_timeout;

`ifdef LOADER_CHECKSUM_EN
    logic [7:0] r_chk;
    logic [7:0] w_chk_nxt;
`endif

    function automatic logic [ADDR_W-1:0] last_addr(input logic [1:0] sel);
        case (sel)
            TGT_BG:         return ADDR_W'(BG_SIZE - 1);
            TGT_P1, TGT_P2: return ADDR_W'(PIKA_SIZE - 1);
            default:        return ADDR_W'(BALL_SIZE - 1);
        endcase
    endfunction

    // FIN is excluded so a timeout can never collide with the done pulse.
    assign w_timeout = (r_state != ST_IDLE) && (r_state != ST_FIN) && !w_byte_valid &&
                       (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state   <= ST_IDLE;
            r_addr    <= '0;
            r_red     <= '0;
            r_wr_en   <= 1'b0;
            r_wr_sel  <= '0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_tmo_cnt <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_chk     <= '0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            r_addr    <= w_addr_nxt;
            r_red     <= w_red_nxt;
            r_wr_en   <= w_wr_en_nxt;
            r_wr_sel  <= w_wr_sel_nxt;
            r_wr_addr <= w_wr_addr_nxt;
            r_wr_data <= w_wr_data_nxt;
            r_done    <= w_done_nxt;
            r_err     <= w_err_nxt;
            r_tmo_cnt <= (r_state == ST_IDLE || w_byte_valid) ? '0 : r_tmo_cnt + 1'b1;
`ifdef LOADER_CHECKSUM_EN
            r_chk     <= w_chk_nxt;
`endif
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_addr_nxt    = r_addr;
        w_red_nxt     = r_red;
        w_wr_en_nxt   = 1'b0;
        w_wr_sel_nxt  = r_wr_sel;
        w_wr_addr_nxt = r_wr_addr;
        w_wr_data_nxt = r_wr_data;
        w_done_nxt    = 1'b0;
        w_err_nxt     = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        w_chk_nxt     = r_chk;
`endif
        // In FIN the done pulse takes precedence so done and err stay exclusive.
        if (w_frame_err && r_state != ST_FIN) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_IDLE;
        end else if (w_timeout) begin
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_byte_valid && w_byte == SYNC_BYTE) begin
                        w_state_nxt = ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (w_byte_valid) begin
                        if (w_byte <= {6'd0, TGT_BALL}) begin
                            w_wr_sel_nxt = w_byte[1:0];
                            w_addr_nxt   = '0;
                            w_state_nxt  = ST_PIX_HI;
`ifdef LOADER_CHECKSUM_EN
                            w_chk_nxt    = '0;
`endif
                        end else begin
                            w_err_nxt   = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end
                ST_PIX_HI: begin
                    if (w_byte_valid) begin
                        w_red_nxt   = w_byte[3:0];
                        w_state_nxt = ST_PIX_LO;
`ifdef LOADER_CHECKSUM_EN
                        w_chk_nxt   = r_chk ^ w_byte;
`endif
                    end
                end
                ST_PIX_LO: begin
                    if (w_byte_valid) begin
                        w_wr_en_nxt   = 1'b1;
                        w_wr_addr_nxt = r_addr;
                        w_wr_data_nxt = {r_red, w_byte};
`ifdef LOADER_CHECKSUM_EN
                        w_chk_nxt     = r_chk ^ w_byte;
`endif
                        if (r_addr == last_addr(r_wr_sel)) begin
`ifdef LOADER_CHECKSUM_EN
                            w_state_nxt = ST_CHK;
`else
                            w_state_nxt = ST_FIN;
`endif
                        end else begin
                            w_addr_nxt  = r_addr + 1'b1;
                            w_state_nxt = ST_PIX_HI;
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                ST_CHK: begin
                    if (w_byte_valid) begin
                        if (w_byte == r_chk) begin
                            w_state_nxt = ST_FIN;
                        end else begin
                            w_err_nxt   = 1'b1;
                            w_state_nxt = ST_IDLE;
                        end
                    end
                end
`endif
                ST_FIN: begin
                    w_done_nxt = 1'b1;
                    // A byte landing in this cycle is treated as idle traffic.
                    w_state_nxt = (w_byte_valid && w_byte == SYNC_BYTE) ? ST_HDR : ST_IDLE;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign o_wr_en   = r_wr_en;
    assign o_wr_sel  = r_wr_sel;
    assign o_wr_addr = r_wr_addr;
    assign o_wr_data = r_wr_data;
    assign o_busy    = (r_state != ST_IDLE);
    assign o_done    = r_done;
    assign o_err     = r_err;

endmodule

// File: tb/tb_sprite_uart_loader.sv
// Testbench for sprite_uart_loader: scaled-down clock/baud and store sizes,
// UART bytes driven serially, SRAM writes collected by a negedge monitor and
// compared against a packet-level reference built from the pixel bytes sent.
module tb_sprite_uart_loader;

    localparam int CLK_HZ      = 1_600_000;
    localparam int BAUD        = 100_000;
    localparam int CPB         = CLK_HZ / BAUD;
    localparam int BG_SIZE     = 32;
    localparam int PIKA_SIZE   = 20;
    localparam int BALL_SIZE   = 12;
    localparam int TIMEOUT_CYC = 1000;

    typedef struct packed {
        logic [1:0]  sel;
        logic [16:0] addr;
        logic [11:0] data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        uart_rx;
    logic        wr_en;
    logic [1:0]  wr_sel;
    logic [16:0] wr_addr;
    logic [11:0] wr_data;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_errors = 0;
    int n_done   = 0;
    int n_err    = 0;
    int n_both   = 0;
    wr_t got_q[$];

    always #5 clk = ~clk;

    sprite_uart_loader #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .BG_SIZE(BG_SIZE), .PIKA_SIZE(PIKA_SIZE),
        .BALL_SIZE(BALL_SIZE), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .i_clk(clk), .i_reset_n(reset_n), .i_uart_rx(uart_rx),
        .o_wr_en(wr_en), .o_wr_sel(wr_sel), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
        .o_busy(busy), .o_done(done), .o_err(err)
    );

    always @(negedge clk) begin
        if (reset_n) begin
            if (wr_en) begin
                wr_t w;
                w.sel  = wr_sel;
                w.addr = wr_addr;
                w.data = wr_data;
                got_q.push_back(w);
            end
            if (done) n_done++;
            if (err) n_err++;
            if (done && err) n_both++;
        end
    end

    function automatic int store_size(input logic [1:0] tgt);
        case (tgt)
            2'd0:    return BG_SIZE;
            2'd1,
            2'd2:    return PIKA_SIZE;
            default: return BALL_SIZE;
        endcase
    endfunction

    task automatic clear_mon();
        got_q.delete();
        n_done = 0;
        n_err  = 0;
        n_both = 0;
    endtask

    task automatic idle(input int k);
        if (k > 0) begin
            repeat (k) @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic v);
        uart_rx = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(!bad_stop);
        uart_rx = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        uart_rx = 1'b1;
        #23;
        n_checks++;
        if ({wr_en, wr_sel, wr_addr, wr_data, busy, done, err} !== 35'd0) begin
            n_errors++;
            $display("FAIL reset_hold outputs=%h required 0", {wr_en, wr_sel, wr_addr, wr_data, busy, done, err});
        end
        reset_n = 1'b1;
        clear_mon();
        idle(200);
        n_checks++;
        if ({wr_en, wr_sel, wr_addr, wr_data, busy, done, err} !== 35'd0) begin
            n_errors++;
            $display("FAIL reset_idle outputs=%h required 0", {wr_en, wr_sel, wr_addr, wr_data, busy, done, err});
        end
        n_checks++;
        if (got_q.size() + n_done + n_err != 0) begin
            n_errors++;
            $display("FAIL reset_events writes=%0d done=%0d err=%0d required 0", got_q.size(), n_done, n_err);
        end
    endtask

    // mode 0: all pixel pairs 0F,0F; 1: random pixels, junk and gaps; 2: bad checksum
    task automatic test_packet(input logic [1:0] tgt, input int mode, input string name);
        wr_t         exp_q[$];
        logic [7:0]  chk = 8'h00;
        logic [7:0]  hi, lo, junk;
        int          n = store_size(tgt);
        int          exp_done = (mode == 2) ? 0 : 1;
        clear_mon();
        if (mode == 1) begin
            for (int j = 0; j < 2; j++) begin
                junk = 8'($urandom_range(0, 255));
                if (junk == 8'hA5) junk = 8'h00;
                send_byte(junk, 1'b0);
            end
        end
        send_byte(8'hA5, 1'b0);
        send_byte({6'd0, tgt}, 1'b0);
        n_checks++;
        if (busy !== 1'b1) begin
            n_errors++;
            $display("FAIL %s busy_after_hdr got=%b required 1", name, busy);
        end
        for (int i = 0; i < n; i++) begin
            if (mode == 0) begin
                hi = 8'h0F;
                lo = 8'h0F;
            end else begin
                hi = 8'($urandom_range(0, 255));
                lo = 8'($urandom_range(0, 255));
            end
            exp_q.push_back('{sel: tgt, addr: 17'(i), data: {hi[3:0], lo}});
            chk = chk ^ hi ^ lo;
            send_byte(hi, 1'b0);
            idle((mode == 1) ? $urandom_range(0, 30) : 0);
            send_byte(lo, 1'b0);
            idle((mode == 1) ? $urandom_range(0, 30) : 0);
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte((mode == 2) ? (chk ^ 8'h5A) : chk, 1'b0);
`endif
        idle(40);
        n_checks++;
        if (got_q.size() != n) begin
            n_errors++;
            $display("FAIL %s write_count got=%0d required %0d", name, got_q.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                n_checks++;
                if (got_q[i] !== exp_q[i]) begin
                    n_errors++;
                    $display("FAIL %s write[%0d] got sel=%0d addr=%0d data=%h required sel=%0d addr=%0d data=%h",
                             name, i, got_q[i].sel, got_q[i].addr, got_q[i].data,
                             exp_q[i].sel, exp_q[i].addr, exp_q[i].data);
                end
            end
        end
        n_checks++;
        if (n_done != exp_done || n_err != 1 - exp_done || n_both != 0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL %s end_state done=%0d err=%0d both=%0d busy=%b required done=%0d err=%0d both=0 busy=0",
                     name, n_done, n_err, n_both, busy, exp_done, 1 - exp_done);
        end
    endtask

    task automatic test_bad_header();
        clear_mon();
        send_byte(8'h5A, 1'b0);
        idle(5);
        n_checks++;
        if (busy !== 1'b0 || n_err != 0) begin
            n_errors++;
            $display("FAIL hdr_junk_ignored busy=%b err=%0d required busy=0 err=0", busy, n_err);
        end
        send_byte(8'hA5, 1'b0);
        send_byte(8'h04, 1'b0);
        idle(10);
        n_checks++;
        if (n_err != 1 || n_done != 0 || got_q.size() != 0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL hdr_bad_target err=%0d done=%0d writes=%0d busy=%b required err=1 done=0 writes=0 busy=0",
                     n_err, n_done, got_q.size(), busy);
        end
    endtask

    task automatic test_timeout();
        wr_t w;
        clear_mon();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h01, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        idle(TIMEOUT_CYC - 300);
        n_checks++;
        if (n_err != 0 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL timeout_early err=%0d busy=%b required err=0 busy=1", n_err, busy);
        end
        idle(400);
        n_checks++;
        if (n_err != 1 || n_done != 0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL timeout_err err=%0d done=%0d busy=%b required err=1 done=0 busy=0", n_err, n_done, busy);
        end
        w = '{sel: 2'd1, addr: 17'd0, data: 12'h234};
        n_checks++;
        if (got_q.size() != 1) begin
            n_errors++;
            $display("FAIL timeout_write_count got=%0d required 1", got_q.size());
        end else if (got_q[0] !== w) begin
            n_errors++;
            $display("FAIL timeout_write got=%h required %h", got_q[0], w);
        end
        test_packet(2'd1, 1, "p1_after_timeout");
    endtask

    task automatic test_frame_err();
        clear_mon();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h02, 1'b0);
        send_byte(8'h3C, 1'b0);
        send_byte(8'h55, 1'b1);
        idle(20);
        n_checks++;
        if (n_err != 1 || n_done != 0 || got_q.size() != 0 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL frame_err err=%0d done=%0d writes=%0d busy=%b required err=1 done=0 writes=0 busy=0",
                     n_err, n_done, got_q.size(), busy);
        end
    endtask

    task automatic test_reset_mid_packet();
        clear_mon();
        send_byte(8'hA5, 1'b0);
        send_byte(8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            send_byte(8'h07, 1'b0);
            send_byte(8'($urandom_range(1, 255)), 1'b0);
        end
        n_checks++;
        if (got_q.size() != 3 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL bg_partial writes=%0d busy=%b required writes=3 busy=1", got_q.size(), busy);
        end
        #3 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({wr_en, wr_sel, wr_addr, wr_data, busy, done, err} !== 35'd0) begin
            n_errors++;
            $display("FAIL async_reset outputs=%h required 0", {wr_en, wr_sel, wr_addr, wr_data, busy, done, err});
        end
        idle(3);
        reset_n = 1'b1;
        idle(10);
        test_packet(2'd2, 1, "p2_after_reset");
    endtask

    initial begin
        test_reset();
        test_packet(2'd3, 0, "ball_0f0f");
        test_bad_header();
        test_timeout();
        test_frame_err();
        test_reset_mid_packet();
        test_packet(2'd0, 1, "bg_random");
        test_packet(2'($urandom_range(0, 3)), 1, "rand_target");
`ifdef LOADER_CHECKSUM_EN
        test_packet(2'd3, 2, "ball_bad_chk");
        test_packet(2'd3, 1, "ball_good_chk");
`endif
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
